// File: rtl/rom_scan_sequencer_if.sv
// Bundle of the ROM-side and consumer-side signals of rom_scan_sequencer.
//   start, stop, loop_mode : scan control from the host
//   rom_addr / rom_data    : address out to, combinational data back from, the ROM
//   out_data / out_addr    : captured word and its address, qualified by out_valid
//   out_valid / out_ready  : valid-ready handshake toward the consumer
//   busy, done, word_count : scan status
// Modports: master = the sequencer, slave = the host/ROM/consumer side.
interface rom_scan_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              start;
  logic              stop;
  logic              loop_mode;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [15:0]       word_count;

  modport master (
    input  start, stop, loop_mode, rom_data, out_ready,
    output rom_addr, out_data, out_addr, out_valid, busy, done, word_count
  );

  modport slave (
    output start, stop, loop_mode, rom_data, out_ready,
    input  rom_addr, out_data, out_addr, out_valid, busy, done, word_count
  );

endinterface

// File: rtl/rom_scan_sequencer.sv
// Walks a ROM from START_ADDR to END_ADDR (inclusive) in STRIDE steps, waits SETTLE
// cycles per address for the ROM to settle, and presents each word on a valid-ready port.
// Ports:
//   clk   : clock, all state updates on its rising edge
//   reset : synchronous active-high reset
//   bus   : rom_scan_sequencer_if.master (control, ROM address/data, output stream, status)
module rom_scan_sequencer #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = 32'h00400000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 32'h00400074,
  parameter int unsigned       STRIDE     = 4,
  parameter int unsigned       SETTLE     = 1
) (
  input logic                  clk,
  input logic                  reset,
  rom_scan_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StPresent, StDone} state_e;

  // Address compare is done one bit wider so a carry out reads as "past END_ADDR".
  localparam logic [ADDR_W:0] StrideExt  = (ADDR_W + 1)'(STRIDE);
  localparam logic [ADDR_W:0] EndExt     = {1'b0, END_ADDR};
  localparam logic [3:0]      SettleLast = 4'(SETTLE - 1);

  state_e            state_q;
  logic [3:0]        settle_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] oaddr_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       count_q;

  logic [ADDR_W:0]   next_addr;
  logic              next_in_range;

  always_comb begin
    next_addr     = {1'b0, addr_q} + StrideExt;
    next_in_range = (next_addr <= EndExt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      settle_q <= '0;
      addr_q   <= START_ADDR;
      data_q   <= '0;
      oaddr_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else if (bus.stop) begin
      // Abort wins over start and over a pending handshake; the word is dropped.
      state_q <= StIdle;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            state_q  <= StSettle;
            addr_q   <= START_ADDR;
            settle_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        StSettle: begin
          if (settle_q == SettleLast) begin
            settle_q <= '0;
            data_q   <= bus.rom_data;
            oaddr_q  <= addr_q;
            valid_q  <= 1'b1;
            state_q  <= StPresent;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        StPresent: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            count_q <= count_q + 16'd1;
            if (next_in_range) begin
              addr_q  <= next_addr[ADDR_W-1:0];
              state_q <= StSettle;
            end else if (bus.loop_mode) begin
              // loop_mode only matters here, at the last word's handshake.
              addr_q  <= START_ADDR;
              state_q <= StSettle;
            end else begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_addr   = addr_q;
  assign bus.out_data   = data_q;
  assign bus.out_addr   = oaddr_q;
  assign bus.out_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.word_count = count_q;

endmodule

// File: tb/tb_rom_scan_sequencer.sv
// Directed bench for rom_scan_sequencer: one default instance and one with
// STRIDE=8 / END_ADDR=0x00400014 / SETTLE=3. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_rom_scan_sequencer;

  localparam logic [31:0] Start = 32'h00400000;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  rom_scan_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  rom_scan_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  rom_scan_sequencer dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  rom_scan_sequencer #(
    .STRIDE   (8),
    .END_ADDR (32'h00400014),
    .SETTLE   (3)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hDEADBEEF;
  endfunction

  assign bus0.rom_data = rom_word(bus0.rom_addr);
  assign bus1.rom_data = rom_word(bus1.rom_addr);

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus0.rom_addr, bus0.out_data, bus0.out_addr} !== {Start, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_regs0: addr=%h data=%h oaddr=%h want %h/0/0",
               bus0.rom_addr, bus0.out_data, bus0.out_addr, Start);
    end
    tests_run++;
    if ({bus0.out_valid, bus0.busy, bus0.done, bus0.word_count} !== 19'h0) begin
      tests_failed++;
      $display("FAIL reset_status0: valid=%b busy=%b done=%b wc=%0d want all 0",
               bus0.out_valid, bus0.busy, bus0.done, bus0.word_count);
    end
    tests_run++;
    if ({bus1.rom_addr, bus1.out_valid, bus1.busy, bus1.done} !== {Start, 3'b000}) begin
      tests_failed++;
      $display("FAIL reset_dut1: addr=%h valid=%b busy=%b done=%b want %h/0/0/0",
               bus1.rom_addr, bus1.out_valid, bus1.busy, bus1.done, Start);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pass();
    logic [31:0] exp_addr;
    int cyc;
    bus0.loop_mode = 1'b0;
    bus0.out_ready = 1'b1;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      exp_addr = Start + 32'(4 * i);
      cyc = 1;
      while (!bus0.out_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      tests_run++;
      if (cyc !== 2) begin
        tests_failed++;
        $display("FAIL single_gap word %0d: got %0d cycles, want 2", i, cyc);
      end
      tests_run++;
      if ({bus0.out_addr, bus0.out_data} !== {exp_addr, rom_word(exp_addr)}) begin
        tests_failed++;
        $display("FAIL single_word %0d: got %h/%h, want %h/%h", i, bus0.out_addr,
                 bus0.out_data, exp_addr, rom_word(exp_addr));
      end
      tests_run++;
      if (bus0.word_count !== 16'(i)) begin
        tests_failed++;
        $display("FAIL single_count word %0d: got %0d, want %0d", i, bus0.word_count, i);
      end
      @(negedge clk);
    end
    tests_run++;
    if ({bus0.done, bus0.busy, bus0.out_valid, bus0.word_count} !== {3'b100, 16'd30}) begin
      tests_failed++;
      $display("FAIL single_end: done=%b busy=%b valid=%b wc=%0d, want 1/0/0/30",
               bus0.done, bus0.busy, bus0.out_valid, bus0.word_count);
    end
  endtask

  task automatic test_random_ready();
    logic [31:0] exp_addr;
    int n;
    logic r;
    logic hs;
    bus0.loop_mode = 1'b0;
    bus0.out_ready = 1'b0;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      exp_addr = Start + 32'(4 * i);
      n = 0;
      while (!bus0.out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      hs = 1'b0;
      n = 0;
      while (!hs && n < 50) begin
        tests_run++;
        if ({bus0.out_valid, bus0.out_addr, bus0.out_data} !==
            {1'b1, exp_addr, rom_word(exp_addr)}) begin
          tests_failed++;
          $display("FAIL rand_hold word %0d cyc %0d: got %b/%h/%h, want 1/%h/%h", i, n,
                   bus0.out_valid, bus0.out_addr, bus0.out_data, exp_addr, rom_word(exp_addr));
        end
        // First cycle of every word stalls so holding is always exercised.
        r = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
        bus0.out_ready = r;
        @(negedge clk);
        hs = r;
        n++;
      end
      bus0.out_ready = 1'b0;
    end
    tests_run++;
    if ({bus0.done, bus0.word_count} !== {1'b1, 16'd30}) begin
      tests_failed++;
      $display("FAIL rand_end: done=%b wc=%0d, want 1/30", bus0.done, bus0.word_count);
    end
  endtask

  task automatic test_stride();
    logic [31:0] exp_addr;
    int cyc;
    bus1.loop_mode = 1'b0;
    bus1.out_ready = 1'b1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_addr = Start + 32'(8 * i);
      cyc = 1;
      while (!bus1.out_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      tests_run++;
      if (cyc !== 4) begin
        tests_failed++;
        $display("FAIL stride_gap word %0d: got %0d cycles, want 4", i, cyc);
      end
      tests_run++;
      if ({bus1.out_addr, bus1.out_data} !== {exp_addr, rom_word(exp_addr)}) begin
        tests_failed++;
        $display("FAIL stride_word %0d: got %h/%h, want %h/%h", i, bus1.out_addr,
                 bus1.out_data, exp_addr, rom_word(exp_addr));
      end
      @(negedge clk);
    end
    tests_run++;
    if ({bus1.done, bus1.busy, bus1.word_count} !== {2'b10, 16'd3}) begin
      tests_failed++;
      $display("FAIL stride_end: done=%b busy=%b wc=%0d, want 1/0/3",
               bus1.done, bus1.busy, bus1.word_count);
    end
  endtask

  task automatic test_loop();
    logic [31:0] exp_addr;
    int cyc;
    bus0.loop_mode = 1'b1;
    bus0.out_ready = 1'b1;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    for (int i = 0; i < 31; i++) begin
      exp_addr = Start + 32'(4 * (i % 30));
      cyc = 1;
      while (!bus0.out_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      tests_run++;
      if ({bus0.out_addr, bus0.out_data} !== {exp_addr, rom_word(exp_addr)} || cyc !== 2) begin
        tests_failed++;
        $display("FAIL loop_word %0d: got %h/%h after %0d cycles, want %h/%h after 2", i,
                 bus0.out_addr, bus0.out_data, cyc, exp_addr, rom_word(exp_addr));
      end
      @(negedge clk);
    end
    tests_run++;
    if ({bus0.done, bus0.busy, bus0.word_count} !== {2'b01, 16'd31}) begin
      tests_failed++;
      $display("FAIL loop_end: done=%b busy=%b wc=%0d, want 0/1/31",
               bus0.done, bus0.busy, bus0.word_count);
    end
    bus0.stop = 1'b1;
    @(negedge clk);
    bus0.stop = 1'b0;
    bus0.loop_mode = 1'b0;
    tests_run++;
    if ({bus0.busy, bus0.out_valid, bus0.done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL loop_stop: busy=%b valid=%b done=%b, want 0/0/0",
               bus0.busy, bus0.out_valid, bus0.done);
    end
  endtask

  task automatic test_stop();
    logic [31:0] exp_addr;
    int n;
    bus0.out_ready = 1'b1;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_addr = Start + 32'(4 * i);
      n = 0;
      while (!bus0.out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      tests_run++;
      if ({bus0.out_addr, bus0.word_count} !== {exp_addr, 16'(i)}) begin
        tests_failed++;
        $display("FAIL stop_word %0d: got %h wc=%0d, want %h wc=%0d", i, bus0.out_addr,
                 bus0.word_count, exp_addr, i);
      end
      if (i == 2) bus0.start = 1'b1;  // must be ignored while busy
      if (i == 4) bus0.stop = 1'b1;   // must beat the handshake
      @(negedge clk);
      bus0.start = 1'b0;
    end
    bus0.stop = 1'b0;
    tests_run++;
    if ({bus0.out_valid, bus0.busy, bus0.done, bus0.word_count} !== {3'b000, 16'd4}) begin
      tests_failed++;
      $display("FAIL stop_idle: valid=%b busy=%b done=%b wc=%0d, want 0/0/0/4",
               bus0.out_valid, bus0.busy, bus0.done, bus0.word_count);
    end
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    tests_run++;
    if ({bus0.word_count, bus0.rom_addr, bus0.busy} !== {16'd0, Start, 1'b1}) begin
      tests_failed++;
      $display("FAIL stop_restart: wc=%0d addr=%h busy=%b, want 0/%h/1",
               bus0.word_count, bus0.rom_addr, bus0.busy, Start);
    end
    n = 0;
    while (!bus0.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (bus0.out_addr !== Start) begin
      tests_failed++;
      $display("FAIL stop_first: got %h, want %h", bus0.out_addr, Start);
    end
    bus0.stop = 1'b1;
    @(negedge clk);
    bus0.stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bus0.out_ready = 1'b1;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    cyc = 0;
    while (!bus0.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);  // first word accepted, now settling on Start+4
    tests_run++;
    if ({bus0.busy, bus0.out_valid, bus0.rom_addr} !== {2'b10, Start + 32'd4}) begin
      tests_failed++;
      $display("FAIL rmid_settle: busy=%b valid=%b addr=%h, want 1/0/%h",
               bus0.busy, bus0.out_valid, bus0.rom_addr, Start + 32'd4);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus0.rom_addr, bus0.out_data, bus0.out_addr} !== {Start, 32'h0, 32'h0}) begin
      tests_failed++;
      $display("FAIL rmid_regs: addr=%h data=%h oaddr=%h, want %h/0/0",
               bus0.rom_addr, bus0.out_data, bus0.out_addr, Start);
    end
    tests_run++;
    if ({bus0.out_valid, bus0.busy, bus0.done, bus0.word_count} !== 19'h0) begin
      tests_failed++;
      $display("FAIL rmid_status: valid=%b busy=%b done=%b wc=%0d, want all 0",
               bus0.out_valid, bus0.busy, bus0.done, bus0.word_count);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus0.busy, bus0.out_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rmid_needs_start: busy=%b valid=%b, want 0/0", bus0.busy, bus0.out_valid);
    end
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    cyc = 1;
    while (!bus0.out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if ({bus0.out_addr, bus0.out_data} !== {Start, rom_word(Start)} || cyc !== 2) begin
      tests_failed++;
      $display("FAIL rmid_restart: got %h/%h after %0d cycles, want %h/%h after 2",
               bus0.out_addr, bus0.out_data, cyc, Start, rom_word(Start));
    end
    bus0.stop = 1'b1;
    @(negedge clk);
    bus0.stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.start = 1'b0;
    bus0.stop = 1'b0;
    bus0.loop_mode = 1'b0;
    bus0.out_ready = 1'b0;
    bus1.start = 1'b0;
    bus1.stop = 1'b0;
    bus1.loop_mode = 1'b0;
    bus1.out_ready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_single_pass();
    test_random_ready();
    test_stride();
    test_loop();
    test_stop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
